// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a two-half-adder full-adder cell
// with a registered carry. start/busy/done handshake; sum/cout hold until the next result.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic [CW-1:0]    cnt;
   logic             carry, carry_nxt;
   logic             s0, c0, s1, c1;
   logic             last;

   half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s0), .c(c0));
   half_adder u_ha1 (.x(s0),      .y(carry),   .s(s1), .c(c1));

   assign carry_nxt = c0 | c1;
   // Shift form keeps WIDTH=1 legal: the new bit lands directly in bit 0.
   assign res_nxt   = (res_sh >> 1) | (WIDTH'(s1) << (WIDTH-1));
   assign last      = (cnt == CW'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
         end
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= res_nxt;
         carry  <= carry_nxt;
         cnt    <= cnt + CW'(1);
         if (last) begin
            sum  <= res_nxt;
            cout <= carry_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 handshake/latency/reset cases plus an
// exhaustive WIDTH=4 sweep against a + b + cin.

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for done8 after an accepted start; returns edges waited or -1.
   task automatic wait_done8(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done8) begin n = i; break; end
      end
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic ec);
      int n;
      a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(n);
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_sum"}, sum8, es);
      chk({tag, "_cout"}, cout8, ec);
   endtask

   initial begin
      int done_cnt, busy_cnt, done_at, n;
      int pos[$];
      bit seen;

      // Reset state
      #12;
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_sum8",  sum8,  0);
      chk("rst_cout8", cout8, 0);
      chk("rst_busy4", busy4, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic add, busy width and done position
      a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("t1_busy_e0", busy8, 1);
      chk("t1_done_e0", done8, 0);
      busy_cnt = 1; done_cnt = 0; done_at = -1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (busy8) busy_cnt++;
         if (done8) begin done_cnt++; done_at = i; end
         if (!done8 && busy8) chk("t1_sum_hold", sum8, 0);
      end
      chk("t1_busy_cycles", busy_cnt, 9);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_at", done_at, 8);
      chk("t1_sum", sum8, 8'h96);
      chk("t1_cout", cout8, 0);

      // 2: wrap-around cases
      op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      @(posedge clk); #1;
      op8("t2c", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);
      @(posedge clk); #1;

      // 3: start re-pulsed during RUN and DONE is ignored
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      done_cnt = 0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         if (done8) done_cnt++;
         if (i == 3) begin start8 = 1'b1; a8 = 8'hAA; end
         if (i == 4) start8 = 1'b0;
         if (i == 8) begin chk("t3_done_at8", done8, 1); start8 = 1'b1; end
         if (i == 9) begin chk("t3_busy_after", busy8, 0); start8 = 1'b0; end
      end
      chk("t3_done_cnt", done_cnt, 1);
      chk("t3_sum", sum8, 8'h30);
      chk("t3_cout", cout8, 0);

      // 4: asynchronous reset mid-operation
      a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_busy", busy8, 0);
      chk("t4_done", done8, 0);
      chk("t4_sum", sum8, 0);
      chk("t4_cout", cout8, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8 || busy8) done_cnt++;
      end
      chk("t4_no_done", done_cnt, 0);
      op8("t4_after", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      @(posedge clk); #1;

      // 5: start held high -> back-to-back ops every WIDTH+2 cycles
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      seen = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done8) begin pos.push_back(i); seen = 1'b1; end
         if (seen) chk("t5_sum_stable", sum8, 8'h02);
      end
      start8 = 1'b0;
      chk("t5_done_cnt", pos.size(), 3);
      if (pos.size() == 3) begin
         chk("t5_pos0", pos[0], 8);
         chk("t5_pos1", pos[1], 18);
         chk("t5_pos2", pos[2], 28);
      end
      wait_done8(n);
      chk("t5_drain", (n > 0), 1);
      chk("t5_last_sum", sum8, 8'h02);
      @(posedge clk); #1;

      // 6: exhaustive WIDTH=4 sweep
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               logic [4:0] exp;
               exp = 5'(ia) + 5'(ib) + 5'(ic);
               a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0]; start4 = 1'b1;
               @(posedge clk); #1;
               start4 = 1'b0;
               n = -1;
               for (int k = 1; k <= 12; k++) begin
                  @(posedge clk); #1;
                  if (done4) begin n = k; break; end
               end
               if (n < 0) chk("t6_timeout", n, 4);
               else       chk("t6_sum", {cout4, sum4}, exp);
               @(posedge clk); #1;
            end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
